// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with HI/LO registers.
// Shift-add multiply, restoring divide, one bit per cycle plus a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int W2 = 2 * WIDTH;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             pneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] opnd_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_signed;
  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic             dz;
  logic             last;

  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign amag      = a_neg ? (WIDTH'(0) - a) : a;
  assign bmag      = b_neg ? (WIDTH'(0) - b) : b;
  assign dz        = is_div & (b == '0);
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));

  // Multiply step: acc = {partial product, remaining multiplier}
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend/quotient bits}
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;

  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0]
                            : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign prod   = pneg_q ? (W2'(0) - acc_q) : acc_q;
  assign quo    = pneg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0])
                         : acc_q[WIDTH-1:0];
  assign rem    = rneg_q ? (WIDTH'(0) - acc_q[W2-1:WIDTH])
                         : acc_q[W2-1:WIDTH];
  assign fix_hi = is_div_q ? rem : prod[W2-1:WIDTH];
  assign fix_lo = is_div_q ? quo : prod[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = dz ? FIX : CALC;
      CALC: if (last) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      pneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            is_div_q <= is_div;
            opnd_q   <= is_div ? bmag : amag;
            pneg_q   <= (a_neg ^ b_neg) & ~dz;
            rneg_q   <= a_neg & is_div & ~dz;
            // Divide by zero parks the final answer in acc for FIX
            acc_q    <= dz ? {a, {WIDTH{1'b1}}}
                           : {{WIDTH{1'b0}}, is_div ? amag : bmag};
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= is_div_q ? div_next : mul_next;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 4-bit instances checked every cycle
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       st, mh, ml;
  logic [1:0][1:0]  opv;
  logic [1:0][31:0] av, bv, wd;

  logic [31:0] hi32, lo32;
  logic [3:0]  hi4, lo4;
  logic        busy32, done32, busy4, done4;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st[0]), .op(opv[0]),
    .a(av[0]), .b(bv[0]), .mthi(mh[0]), .mtlo(ml[0]),
    .wdata(wd[0]), .hi(hi32), .lo(lo32),
    .busy(busy32), .done(done32)
  );

  muldiv_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[1]), .op(opv[1]),
    .a(av[1][3:0]), .b(bv[1][3:0]), .mthi(mh[1]), .mtlo(ml[1]),
    .wdata(wd[1][3:0]), .hi(hi4), .lo(lo4),
    .busy(busy4), .done(done4)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(string name, longint unsigned act,
                     longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int wid(int u);
    return (u == 0) ? 32 : 4;
  endfunction

  function automatic longint unsigned msk(int u);
    return (64'd1 << wid(u)) - 64'd1;
  endfunction

  // Reference: plain signed/unsigned arithmetic on 64-bit values
  function automatic void refop(int w, logic [1:0] op,
                                longint unsigned a, longint unsigned b,
                                output longint unsigned rh,
                                output longint unsigned rl);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (64'sd1 << w);
    if (b[w-1]) sb = sb - (64'sd1 << w);
    rh = 0;
    rl = 0;
    case (op)
      2'd0: begin
        p  = sa * sb;
        rl = longint'(p) & m;
        rh = (longint'(p) >>> w) & m;
      end
      2'd1: begin
        up = a * b;
        rl = up & m;
        rh = (up >> w) & m;
      end
      default: begin
        if (b == 0) begin
          rl = m;
          rh = a;
        end else if (op == 2'd2) begin
          q  = sa / sb;
          r  = sa % sb;
          rl = longint'(q) & m;
          rh = longint'(r) & m;
        end else begin
          rl = (a / b) & m;
          rh = (a % b) & m;
        end
      end
    endcase
  endfunction

  longint unsigned m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  int              m_rem[2];
  bit              m_done[2];
  bit              armed = 0;

  // m_rem = edges left until the pending result lands
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_hi[u] = 0; m_lo[u] = 0;
        m_rem[u] = 0; m_done[u] = 0;
      end else begin
        m_done[u] = 0;
        if (m_rem[u] > 0) begin
          m_rem[u]--;
          if (m_rem[u] == 0) begin
            m_hi[u] = p_hi[u];
            m_lo[u] = p_lo[u];
            m_done[u] = 1;
          end
        end else if (st[u]) begin
          refop(wid(u), opv[u], av[u] & msk(u), bv[u] & msk(u),
                p_hi[u], p_lo[u]);
          m_rem[u] = (opv[u][1] && (bv[u] & msk(u)) == 0)
                   ? 1 : wid(u) + 1;
        end else begin
          if (mh[u]) m_hi[u] = wd[u] & msk(u);
          if (ml[u]) m_lo[u] = wd[u] & msk(u);
        end
      end
    end
    if (rst) armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("u0 hi", hi32, m_hi[0]);
      chk("u0 lo", lo32, m_lo[0]);
      chk("u0 busy", busy32, m_rem[0] != 0);
      chk("u0 done", done32, m_done[0]);
      chk("u1 hi", hi4, m_hi[1]);
      chk("u1 lo", lo4, m_lo[1]);
      chk("u1 busy", busy4, m_rem[1] != 0);
      chk("u1 done", done4, m_done[1]);
    end
  end

  task automatic clear_in();
    st = '0; mh = '0; ml = '0;
  endtask

  task automatic wait_idle(int u);
    int n = 0;
    while (m_rem[u] != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_rem[u] != 0) begin
      total++;
      $display("FAIL idle_timeout u%0d", u);
    end
  endtask

  // Called at a negedge while idle; returns at the first idle negedge
  task automatic issue(int u, logic [1:0] op, logic [31:0] a,
                       logic [31:0] b, bit noise);
    st[u] = 1'b1; opv[u] = op; av[u] = a; bv[u] = b;
    @(negedge clk);
    st[u] = 1'b0;
    while (m_rem[u] != 0) begin
      if (noise) begin
        st[u] = 1'($urandom_range(0, 1));
        mh[u] = 1'($urandom_range(0, 1));
        ml[u] = 1'($urandom_range(0, 1));
        opv[u] = 2'($urandom_range(0, 3));
        av[u] = $urandom; bv[u] = $urandom; wd[u] = $urandom;
      end
      @(negedge clk);
    end
    clear_in();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd;
    rst = 1'b1;
    clear_in();
    opv = '0; av = '0; bv = '0; wd = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset hi", hi32, 0);
    chk("reset lo", lo32, 0);
    chk("reset busy", busy32, 0);

    st[0] = 1'b1; opv[0] = 2'd1;
    av[0] = 32'hFFFFFFFF; bv[0] = 32'hFFFFFFFF;
    @(negedge clk);
    st[0] = 1'b0;
    nb = 0; nd = 0;
    repeat (40) begin
      nb += int'(busy32);
      nd += int'(done32);
      @(negedge clk);
    end
    chk("t1 busy cycles", nb, 33);
    chk("t1 done cycles", nd, 1);
    chk("t1 hi", hi32, 32'hFFFFFFFE);
    chk("t1 lo", lo32, 32'h00000001);

    issue(0, 2'd0, 32'hFFFFFFFD, 32'd5, 0);
    chk("t2 mult hi", hi32, 32'hFFFFFFFF);
    chk("t2 mult lo", lo32, 32'hFFFFFFF1);
    issue(0, 2'd3, 32'd100, 32'd7, 0);
    chk("t2 divu lo", lo32, 14);
    chk("t2 divu hi", hi32, 2);

    issue(0, 2'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("t3 div lo", lo32, 32'hFFFFFFFD);
    chk("t3 div hi", hi32, 32'hFFFFFFFF);

    issue(0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("t4 ovf lo", lo32, 32'h80000000);
    chk("t4 ovf hi", hi32, 0);

    st[0] = 1'b1; opv[0] = 2'd3; av[0] = 32'h1234; bv[0] = 0;
    @(negedge clk);
    st[0] = 1'b0;
    chk("t4 dz busy", busy32, 1);
    @(negedge clk);
    chk("t4 dz done", done32, 1);
    chk("t4 dz lo", lo32, 32'hFFFFFFFF);
    chk("t4 dz hi", hi32, 32'h1234);

    mh[0] = 1'b1; ml[0] = 1'b1; wd[0] = 32'hA5A5A5A5;
    @(negedge clk);
    clear_in();
    chk("t5 mthi", hi32, 32'hA5A5A5A5);
    chk("t5 mtlo", lo32, 32'hA5A5A5A5);

    st[0] = 1'b1; opv[0] = 2'd1; av[0] = 6; bv[0] = 7;
    @(negedge clk);
    st[0] = 1'b0; mh[0] = 1'b1; wd[0] = 32'hDEADBEEF;
    @(negedge clk);
    mh[0] = 1'b0; st[0] = 1'b1; opv[0] = 2'd3;
    av[0] = 32'd50; bv[0] = 32'd3;
    @(negedge clk);
    st[0] = 1'b0;
    wait_idle(0);
    chk("t5 busy-ignore hi", hi32, 0);
    chk("t5 busy-ignore lo", lo32, 42);
    repeat (3) @(negedge clk);
    chk("t5 no restart", busy32, 0);

    st[0] = 1'b1; ml[0] = 1'b1; wd[0] = 32'h1111;
    opv[0] = 2'd1; av[0] = 3; bv[0] = 4;
    @(negedge clk);
    clear_in();
    wait_idle(0);
    chk("t5 start-wins lo", lo32, 12);
    chk("t5 start-wins hi", hi32, 0);

    st[0] = 1'b1; opv[0] = 2'd1; av[0] = 9; bv[0] = 9;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 rst hi", hi32, 0);
    chk("t5 rst lo", lo32, 0);
    chk("t5 rst busy", busy32, 0);
    nd = 0;
    repeat (40) begin
      nd += int'(done32);
      @(negedge clk);
    end
    chk("t5 rst no done", nd, 0);

    issue(1, 2'd0, 32'h8, 32'h8, 0);
    chk("t6 w4 hi", hi4, 4'h4);
    chk("t6 w4 lo", lo4, 4'h0);
    for (int op = 0; op < 4; op++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          issue(1, 2'(op), 32'(x), 32'(y), 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mh[0] = 1'($urandom_range(0, 1));
        ml[0] = 1'($urandom_range(0, 1));
        wd[0] = $urandom;
        @(negedge clk);
        clear_in();
      end
      issue(0, 2'($urandom_range(0, 3)), pick(), pick(), 1);
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
